// File: rtl/fb_arbiter_pkg.sv
// Shared frame-buffer definitions used by the arbiter, the display pane and the draw engine.
package fb_arbiter_pkg;

  localparam int unsigned FB_W     = 320;
  localparam int unsigned FB_H     = 240;
  localparam int unsigned FB_DEPTH = FB_W * FB_H;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fb_arb_starve.sv
// Saturating count of consecutive denied draw cycles; force_draw flags that draw is owed a slot.
module fb_arb_starve #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic draw_req,
  input  logic draw_gnt,
  output logic force_draw
);

  localparam logic [7:0] CNT_MAX = 8'(STARVE_MAX);

  logic [7:0] starve_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!run || !draw_req || draw_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  assign force_draw = run && (starve_cnt == CNT_MAX);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: draw-only while loading a map, read priority with forced draw slots after.
// Optional stall statistic enabled by defining FB_ARB_STATS_EN.
module fb_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FB_DEPTH   = fb_arbiter_pkg::FB_DEPTH,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_wdata,
  output logic              draw_gnt,
  input  logic              draw_map_done,
  input  logic              map_reload,
  output logic              frame_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       disp_stall_cnt
);

  import fb_arbiter_pkg::*;

  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(FB_DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a < DEPTH_LIM;
  endfunction

  arb_state_t state_q, state_d;
  logic       force_draw;
  logic       disp_in_range, draw_in_range;
  logic       rvalid_q, oob_q;

  assign disp_in_range = in_range(disp_addr);
  assign draw_in_range = in_range(draw_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // A reload always wins over a simultaneous map-done pulse.
  always_comb begin
    state_d = state_q;
    if (map_reload)                             state_d = LOAD;
    else if (state_q == LOAD && draw_map_done)  state_d = RUN;
  end

  // NOTE: every output gets a default first so no path through this block can infer a latch.
  always_comb begin
    disp_gnt    = 1'b0;
    draw_gnt    = 1'b0;
    frame_ready = (state_q == RUN);
    if (state_q == LOAD) begin
      draw_gnt = draw_req;
    end else if (force_draw && draw_req) begin
      draw_gnt = 1'b1;
    end else begin
      disp_gnt = disp_req;
      draw_gnt = draw_req & ~disp_req;
    end
  end

  fb_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (state_q == RUN),
    .draw_req   (draw_req),
    .draw_gnt   (draw_gnt),
    .force_draw (force_draw)
  );

  // Out-of-range accesses keep their grant but never enable the RAM.
  always_comb begin
    mem_we    = draw_gnt & draw_in_range;
    mem_en    = (disp_gnt & disp_in_range) | mem_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (draw_gnt) begin
      mem_addr  = draw_addr;
      mem_wdata = draw_wdata;
    end else if (disp_gnt) begin
      mem_addr  = disp_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      rvalid_q <= disp_gnt;
      oob_q    <= disp_gnt & ~disp_in_range;
    end
  end

  assign disp_rvalid = rvalid_q;
  assign disp_rdata  = oob_q ? '0 : mem_rdata;

`ifdef FB_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (map_reload) begin
      stall_q <= '0;
    end else if (state_q == RUN && disp_req && !disp_gnt && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign disp_stall_cnt = stall_q;
`else
  assign disp_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed table, starvation sequence, random traffic, mid-read reset.
module tb_fb_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 76800;
  localparam int SMAX   = 8;

  logic              clk;
  logic              rst_n;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              draw_req;
  logic [ADDR_W-1:0] draw_addr;
  logic [DATA_W-1:0] draw_wdata;
  logic              draw_gnt;
  logic              draw_map_done;
  logic              map_reload;
  logic              frame_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       disp_stall_cnt;

  fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .draw_req(draw_req), .draw_addr(draw_addr), .draw_wdata(draw_wdata), .draw_gnt(draw_gnt),
    .draw_map_done(draw_map_done), .map_reload(map_reload), .frame_ready(frame_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .disp_stall_cnt(disp_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency.
  logic [DATA_W-1:0] ram [0:131071];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: arbitration mode, denied-draw streak, pending read result, shadow picture.
  bit              m_run;
  int              m_streak;
  bit              m_pv;
  bit              m_pk;
  logic [DATA_W-1:0] m_pd;
  int              m_stall;
  logic [DATA_W-1:0] shadow [0:DEPTH-1];
  bit              known  [0:DEPTH-1];

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit              dr;
    logic [ADDR_W-1:0] da;
    bit              wr;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    bit              dn;
    bit              rl;
    bit              e_dg;
    bit              e_wg;
    bit              e_en;
    bit              e_we;
    bit              e_fr;
    bit              e_rv;
    bit              chk_rd;
    logic [DATA_W-1:0] e_rd;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run    = 1'b0;
    m_streak = 0;
    m_pv     = 1'b0;
    m_pk     = 1'b0;
    m_pd     = '0;
    m_stall  = 0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return ADDR_W'(76798 + $urandom_range(0, 5));
    return ADDR_W'($urandom_range(0, 31));
  endfunction

  // Drive one cycle of inputs, compare every output against the model, then advance the model.
  task automatic step(input bit dr, input logic [ADDR_W-1:0] da, input bit wr,
                      input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input bit dn, input bit rl);
    bit eg_disp, eg_draw, e_we, e_en;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    logic [15:0] e_stall;
    @(negedge clk);
    disp_req = dr; disp_addr = da; draw_req = wr; draw_addr = wa; draw_wdata = wd;
    draw_map_done = dn; map_reload = rl;
    #1;
    if (!m_run) begin
      eg_draw = wr; eg_disp = 1'b0;
    end else if (wr && m_streak >= SMAX) begin
      eg_draw = 1'b1; eg_disp = 1'b0;
    end else begin
      eg_disp = dr; eg_draw = wr && !dr;
    end
    e_we   = eg_draw && (int'(wa) < DEPTH);
    e_en   = e_we || (eg_disp && (int'(da) < DEPTH));
    e_addr = eg_draw ? wa : (eg_disp ? da : '0);
    e_wd   = eg_draw ? wd : '0;
`ifdef FB_ARB_STATS_EN
    e_stall = 16'(m_stall);
`else
    e_stall = 16'd0;
`endif
    check("disp_gnt", disp_gnt, eg_disp);
    check("draw_gnt", draw_gnt, eg_draw);
    check("mem_en", mem_en, e_en);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wd);
    check("frame_ready", frame_ready, m_run);
    check("disp_rvalid", disp_rvalid, m_pv);
    if (m_pv && m_pk) check("disp_rdata", disp_rdata, m_pd);
    check("disp_stall_cnt", disp_stall_cnt, e_stall);

    m_pv = eg_disp;
    if (eg_disp) begin
      if (int'(da) < DEPTH) begin
        m_pk = known[int'(da)]; m_pd = shadow[int'(da)];
      end else begin
        m_pk = 1'b1; m_pd = '0;
      end
    end
    if (e_we) begin
      shadow[int'(wa)] = wd; known[int'(wa)] = 1'b1;
    end
    if (m_run && wr && !eg_draw) m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
    else                         m_streak = 0;
    if (rl)                                                  m_stall = 0;
    else if (m_run && dr && !eg_disp && m_stall < 65535)     m_stall++;
    if (rl)      m_run = 1'b0;
    else if (dn) m_run = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{0, 0,     0, 0,     24'h0,      1, 0,  0, 0, 0, 0, 0,  0, 0, 24'h0};
    tbl[1]  = '{1, 5,     0, 0,     24'h0,      0, 0,  1, 0, 1, 0, 1,  0, 0, 24'h0};
    tbl[2]  = '{0, 0,     0, 0,     24'h0,      0, 0,  0, 0, 0, 0, 1,  1, 1, 24'hA00005};
    tbl[3]  = '{1, 76800, 1, 76801, 24'h123456, 0, 0,  1, 0, 0, 0, 1,  0, 0, 24'h0};
    tbl[4]  = '{0, 0,     1, 76801, 24'hFFFFFF, 0, 0,  0, 1, 0, 0, 1,  1, 1, 24'h0};
    tbl[5]  = '{1, 1,     0, 0,     24'h0,      0, 0,  1, 0, 1, 0, 1,  0, 0, 24'h0};
    tbl[6]  = '{0, 0,     0, 0,     24'h0,      0, 0,  0, 0, 0, 0, 1,  1, 1, 24'hA00001};
    tbl[7]  = '{1, 2,     0, 0,     24'h0,      1, 1,  1, 0, 1, 0, 1,  0, 0, 24'h0};
    tbl[8]  = '{1, 2,     0, 0,     24'h0,      0, 0,  0, 0, 0, 0, 0,  1, 1, 24'hA00002};
    tbl[9]  = '{1, 2,     0, 0,     24'h0,      1, 0,  0, 0, 0, 0, 0,  0, 0, 24'h0};
    tbl[10] = '{0, 0,     0, 0,     24'h0,      0, 0,  0, 0, 0, 0, 1,  0, 0, 24'h0};
    tbl[11] = '{0, 0,     1, 7,     24'h0BEEF0, 0, 0,  0, 1, 1, 1, 1,  0, 0, 24'h0};
    tbl[12] = '{1, 7,     0, 0,     24'h0,      0, 0,  1, 0, 1, 0, 1,  0, 0, 24'h0};
    tbl[13] = '{0, 0,     0, 0,     24'h0,      0, 0,  0, 0, 0, 0, 1,  1, 1, 24'h0BEEF0};

    for (int i = 0; i < DEPTH; i++) begin
      shadow[i] = '0; known[i] = 1'b0;
    end
    model_reset();

    // Reset state
    rst_n = 1'b0;
    disp_req = 0; disp_addr = '0; draw_req = 0; draw_addr = '0; draw_wdata = '0;
    draw_map_done = 0; map_reload = 0;
    #1;
    check("rst_frame_ready", frame_ready, 1'b0);
    check("rst_rvalid", disp_rvalid, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_stall", disp_stall_cnt, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Map load: display held off, every draw written
    for (int i = 0; i < 10; i++) begin
      step(1, 17'd3, 1, ADDR_W'(i), 24'hA00000 + DATA_W'(i), 0, 0);
      check("load_draw_gnt", draw_gnt, 1'b1);
      check("load_disp_gnt", disp_gnt, 1'b0);
      check("load_mem_we", mem_we, 1'b1);
      check("load_frame_ready", frame_ready, 1'b0);
    end

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].dr, tbl[i].da, tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].dn, tbl[i].rl);
      check($sformatf("vec%0d_disp_gnt", i), disp_gnt, tbl[i].e_dg);
      check($sformatf("vec%0d_draw_gnt", i), draw_gnt, tbl[i].e_wg);
      check($sformatf("vec%0d_mem_en", i), mem_en, tbl[i].e_en);
      check($sformatf("vec%0d_mem_we", i), mem_we, tbl[i].e_we);
      check($sformatf("vec%0d_frame_ready", i), frame_ready, tbl[i].e_fr);
      check($sformatf("vec%0d_rvalid", i), disp_rvalid, tbl[i].e_rv);
      if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), disp_rdata, tbl[i].e_rd);
    end

    // Both requesters saturating: draw owns every (SMAX+1)-th cycle
    begin
      logic [ADDR_W-1:0] wa;
      wa = 17'd100;
      for (int c = 1; c <= 3 * (SMAX + 1); c++) begin
        step(1, ADDR_W'(c % 10), 1, wa, DATA_W'(24'h5A0000 + c), 0, 0);
        check($sformatf("starve_draw_c%0d", c), draw_gnt, (c % (SMAX + 1)) == 0);
        check($sformatf("starve_disp_c%0d", c), disp_gnt, (c % (SMAX + 1)) != 0);
        if (draw_gnt) wa = wa + 17'd1;
      end
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 60, rand_addr(),
           $urandom_range(0, 99) < 60, rand_addr(), DATA_W'($urandom()),
           $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
    end

    // Reset one cycle after a read grant
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 17'd4, 0, 0, 0, 0, 0);
    check("pre_rst_disp_gnt", disp_gnt, 1'b1);
    @(negedge clk);
    disp_req = 0; draw_req = 0; draw_map_done = 0; map_reload = 0;
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid", disp_rvalid, 1'b0);
    check("midrst_frame_ready", frame_ready, 1'b0);
    check("midrst_stall", disp_stall_cnt, 16'd0);
    check("midrst_mem_en", mem_en, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 17'd4, 0, 0, 0, 0, 0);
    check("postrst_disp_gnt", disp_gnt, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
